// File: rtl/uart_rx_os16_if.sv
// Receive-side byte handshake bundle for uart_rx_os16.
// Latency: pure wiring; no storage of its own.
// Backpressure: the consumer drives rx_o_ready; the receiver holds the byte until it is accepted.
// Ports (master = receiver side):
//    rx_o_data        byte received, bit 0 first on the line
//    rx_o_data_valid  rx_o_data holds an unconsumed byte
//    rx_o_ready       consumer accepts while valid is high
//    rx_o_frame_err   one-clk pulse, stop bit sampled low
//    rx_o_overrun     one-clk pulse, new byte dropped because the holding register was full
interface uart_rx_os16_if #(
   parameter int DataBits = 8
);
   logic [DataBits-1:0] rx_o_data;
   logic                rx_o_data_valid;
   logic                rx_o_ready;
   logic                rx_o_frame_err;
   logic                rx_o_overrun;

   modport master (
      output rx_o_data,
      output rx_o_data_valid,
      input  rx_o_ready,
      output rx_o_frame_err,
      output rx_o_overrun
   );

   modport slave (
      input  rx_o_data,
      input  rx_o_data_valid,
      output rx_o_ready,
      input  rx_o_frame_err,
      input  rx_o_overrun
   );
endinterface

// File: rtl/uart_rx_os16.sv
// UART receiver, 16x oversampled, LSB first, no parity, 1 stop bit, majority vote per bit.
// Latency: byte appears one edge after the mid-stop-bit vote (about 2 + 16*(DataBits+1) + 9 ticks after the start edge).
// Backpressure: one-entry holding register; a new byte arriving while it is full and not accepted is dropped and flagged.
// Ports: clk, rstn (async active-low), rx_en (hold idle when low), i_rx (async serial line),
//        rx (uart_rx_os16_if master: data/valid/ready handshake plus frame_err and overrun pulses).
module uart_rx_os16 #(
   parameter int ClkFreq  = 10_000_000,
   parameter int BaudRate = 9600,
   parameter int DataBits = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               rx_en,
   input  logic               i_rx,
   uart_rx_os16_if.master     rx
);

   localparam int DivRaw = (ClkFreq + 8 * BaudRate) / (16 * BaudRate);
   localparam int Div    = (DivRaw < 1) ? 1 : DivRaw;
   localparam int DivW   = $clog2(Div) + 1;
   localparam logic [2:0] LastIdx = 3'(DataBits - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_next;
   logic                 rx_m, rx_s, rx_prev;
   logic [DivW-1:0]      div_cnt;
   logic [3:0]           os_cnt;
   logic                 vote7, vote8;
   logic [2:0]           bit_idx;
   logic [DataBits-1:0]  shreg;

   logic                 tick, fall, start_det, vote_now, voted;
   logic                 frame_good, frame_bad, bit_we, idx_clr;

   assign tick     = (div_cnt == DivW'(Div - 1));
   assign fall     = rx_prev & ~rx_s;
   assign vote_now = tick && (os_cnt == 4'd9);
   // Majority of the samples taken at os_cnt 7, 8 and the live one at 9.
   assign voted    = (vote7 & vote8) | (vote7 & rx_s) | (vote8 & rx_s);

   // Two-flop synchronizer plus edge-detect history; idle level is 1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_m    <= i_rx;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
      end
   end

   // Tick divider and oversample counter; both restart on the start edge so
   // os_cnt 8 lands in the middle of every bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_cnt <= '0;
         os_cnt  <= '0;
         vote7   <= 1'b0;
         vote8   <= 1'b0;
      end else begin
         if (start_det || tick) div_cnt <= '0;
         else                   div_cnt <= div_cnt + 1'b1;

         if (start_det)  os_cnt <= '0;
         else if (tick)  os_cnt <= os_cnt + 1'b1;

         if (tick && os_cnt == 4'd7) vote7 <= rx_s;
         if (tick && os_cnt == 4'd8) vote8 <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      start_det  = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      bit_we     = 1'b0;
      idx_clr    = 1'b0;
      case (state)
         IDLE: begin
            if (rx_en && fall) begin
               start_det  = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (vote_now) begin
               if (voted) begin
                  state_next = IDLE;        // glitch, not a real start bit
               end else begin
                  idx_clr    = 1'b1;
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (vote_now) begin
               bit_we = 1'b1;
               if (bit_idx == LastIdx) state_next = STOP;
            end
         end
         STOP: begin
            // Leave at mid-stop so the following start edge is not missed.
            if (vote_now) begin
               state_next = IDLE;
               frame_good = voted;
               frame_bad  = ~voted;
            end
         end
         default: state_next = IDLE;
      endcase
      // Disable aborts silently; the holding register keeps working.
      if (!rx_en) begin
         state_next = IDLE;
         start_det  = 1'b0;
         frame_good = 1'b0;
         frame_bad  = 1'b0;
         bit_we     = 1'b0;
         idx_clr    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (idx_clr)     bit_idx <= '0;
         else if (bit_we) bit_idx <= bit_idx + 1'b1;
         if (bit_we) shreg[bit_idx] <= voted;
      end
   end

   // Holding register: an accept in the same cycle as a new byte frees the
   // slot, so the new byte loads and valid stays up without an overrun.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx.rx_o_data       <= '0;
         rx.rx_o_data_valid <= 1'b0;
         rx.rx_o_frame_err  <= 1'b0;
         rx.rx_o_overrun    <= 1'b0;
      end else begin
         rx.rx_o_frame_err <= frame_bad;
         rx.rx_o_overrun   <= frame_good && rx.rx_o_data_valid && !rx.rx_o_ready;
         if (frame_good && (!rx.rx_o_data_valid || rx.rx_o_ready)) begin
            rx.rx_o_data       <= shreg;
            rx.rx_o_data_valid <= 1'b1;
         end else if (rx.rx_o_data_valid && rx.rx_o_ready) begin
            rx.rx_o_data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- Single-clock UART receiver with 16x oversampling. Serves as the receiving end for frames produced by the team's UART transmitter.
- Generates its own oversample tick from the core clock, so no separate baud clock is needed.
- Validates the start bit, majority-votes each bit, and flags framing errors.
- Presents each received byte through a valid/ready holding register and flags overruns.

Parameters:
- ClkFreq, 10_000_000: core clock frequency in Hz.
- BaudRate, 9600: line bit rate in bit/s.
- DataBits, 8: data bits per frame, 5..8. The frame is LSB first, with no parity and 1 stop bit.

Ports:
- clk  input  1  core clock.
- rstn  input  1  reset, asynchronous assert, active-low.
- rx_en  input  1  receiver enable; when low, the receiver is held idle.
- i_rx  input  1  serial line, asynchronous to clk; idles high.
- rx_o_data  output  DataBits  received byte; bit 0 is the first bit received.
- rx_o_data_valid  output  1  rx_o_data holds an unconsumed byte.
- rx_o_ready  input  1  consumer accepts the byte on any cycle where valid and ready are both high.
- rx_o_frame_err  output  1  one-clk pulse when the stop bit samples low.
- rx_o_overrun  output  1  one-clk pulse when a new byte is dropped because the holding register is full.

Behaviour:
- Reset (rstn low, asynchronous):
  - All outputs are 0 and the FSM is in IDLE.
  - Both synchronizer flops and the edge-detect register reset to 1.
  - The tick divider and oversample counter reset to 0.
- Synchronizer: i_rx passes through 2 flops (rx_s). Falling edge = previous rx_s is 1 and current rx_s is 0.
- Tick divider:
  - Div = (ClkFreq + 8*BaudRate) / (16*BaudRate), integer arithmetic, minimum 1.
  - The counter runs 0..Div-1; tick is high for one clk when it wraps.
  - It restarts at 0 on start-edge detection, so sampling phase aligns to the edge.
- Oversample counter os_cnt:
  - 4 bits, advances on each tick, wraps 15 to 0; each wrap is one bit period.
  - Votes take rx_s at os_cnt 7, 8 and 9; the bit value is the majority of the three, decided on the tick where os_cnt == 9.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge with rx_en high, clear os_cnt, restart the divider, go to START.
  - START: at the vote decision, a 1 is a false start and returns to IDLE with no output. A 0 clears bit_idx and goes to DATA.
  - DATA: at each vote decision, shift the voted bit into the shift register at position bit_idx and increment bit_idx. After bit DataBits-1, go to STOP.
  - STOP: at the vote decision, return to IDLE. A voted 1 is a good frame. A voted 0 pulses rx_o_frame_err for one clk and discards the data.
  - Returning to IDLE at mid-stop lets the next start edge be caught.
- Output handshake:
  - A good frame loads rx_o_data and sets rx_o_data_valid on the clk edge following the stop decision.
  - Valid stays high until a cycle with valid and ready both high, then clears on the next edge.
  - rx_o_data is stable while valid is high.
- Simultaneous events:
  - Good frame with valid high and ready low: pulse rx_o_overrun, keep the old byte, drop the new one.
  - Good frame in the same cycle as an accept (valid and ready high): load the new byte, valid stays 1, no overrun.
- rx_en low:
  - The FSM goes to IDLE on the next edge and any frame in progress is aborted with no error pulse.
  - The holding register, valid and handshake keep operating.
  - Re-enabling while the line is low does not start a frame; a fresh falling edge is required.
- Line held low in IDLE (break): no falling edge occurs, so nothing further is received after the first frame error.
- Width rules:
  - bit_idx is a 3-bit count.
  - The divider counter width is clog2(Div)+1.
  - No arithmetic overflow is permitted with the default parameters.

Test Plan:
- All scenarios use ClkFreq=1_600_000 and BaudRate=100_000, giving Div=1 and a bit period of 16 clk.
- Good frame: send 0xA5 (LSB first) with ready held high. rx_o_data = 0xA5 and valid pulses 1 clk. Valid rises about 2 + 16*9 + 9 clk after the start edge.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap and ready high. Both bytes are delivered in order with no frame_err.
- Framing error: send 0x3C with the stop bit held low. rx_o_frame_err pulses 1 clk and valid stays 0. A following valid frame 0x81 (after the line returns high) is received correctly.
- False start: drive i_rx low for 4 clk, then high. No valid and no frame_err; a subsequent 0x5A is received correctly.
- Overrun: ready=0, send 0x11 then 0x22. rx_o_data stays 0x11 with valid high, and rx_o_overrun pulses once at the second stop decision. Raising ready then clears valid.
- Abort and reset: drop rx_en mid-DATA of 0x77, then send 0x66 with rx_en high. Only 0x66 appears. Assert rstn low mid-frame: all outputs are 0 immediately.
